fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction-fetch stage with a prefetch queue between instruction memory and decode. It generates sequential fetch addresses, issues reads to a synchronous single-cycle-latency instruction memory, and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect flushes the FIFO and squashes any in-flight read. This block replaces the fixed-width, stall-driven fetch stage in the pipeline front end.

## Interface
- ADDR_W, 16, PC / instruction-memory address width
- INSTR_W, 16, instruction word width
- DEPTH, 4, prefetch FIFO entries; legal range 3..16. Full throughput requires ≥3.
- RESET_PC, 0, PC loaded on reset (ADDR_W bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- hlt  in  1  suppresses new memory reads; FIFO continues to drain
- redirect  in  1  branch/jump taken; flush and refetch from redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- im_rd_en  out  1  memory read strobe (combinational)
- im_addr  out  ADDR_W  memory read address (combinational)
- im_instr  in  INSTR_W  read data; valid in the cycle after im_rd_en
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_pc_next  out  ADDR_W  out_pc + 1, modulo 2^ADDR_W
- q_count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- State:
  - fetch_pc: next sequential address.
  - inflight flag with inflight_pc: a read was issued last cycle.
  - FIFO: DEPTH entries of {instr, pc}, with rd_ptr, wr_ptr and count.
- Issue condition: issue = !hlt && (count + inflight < DEPTH). A pop in the same cycle does not free a credit.
- Issue address:
  - im_rd_en = issue.
  - im_addr = redirect ? redirect_pc : fetch_pc.
- Normal issue: fetch_pc <= im_addr + 1 (wraps). Then inflight <= 1 and inflight_pc <= im_addr; otherwise inflight <= 0.
- Response: when inflight=1 and no redirect this cycle, push {im_instr, inflight_pc} at the clock edge.
- Pop: out_valid && out_ready removes the head.
  - Push and pop in the same cycle leave count unchanged.
  - The issue rule guarantees a push never overflows.
- Redirect handling, in a cycle with redirect=1:
  - The FIFO is cleared (count <= 0, pointers reset).
  - The in-flight response is discarded.
  - out_valid is forced 0, so no pop occurs.
  - Credit is then computed with count=0, inflight=0, so the target is issued in this same cycle if !hlt.
  - fetch_pc <= redirect_pc + 1 if issued, else redirect_pc.
- Simultaneous events:
  - hlt && redirect: flush occurs, fetch_pc <= redirect_pc, no read.
  - When hlt deasserts, fetch resumes at fetch_pc.
- Wrap-around: all PC arithmetic is modulo 2^ADDR_W. For example, 0xFFFF is followed by 0x0000.

## Timing
- Reset (async) clears: fetch_pc = RESET_PC, inflight = 0, count = 0, pointers = 0. Outputs take the values out_valid=0, q_count=0, out_instr=0, out_pc=0, out_pc_next=1.
- im_rd_en and im_addr follow the issue rule combinationally after reset release. The first read is at RESET_PC in the first clocked cycle.
- Latency from issue to consumer:
  - Read issued in cycle t; data present in cycle t+1; written at the end of t+1.
  - out_valid asserts in cycle t+2. There is no bypass.
- Redirect-to-valid latency: redirect in cycle t gives a target instruction with out_valid in t+2.
- Throughput: with DEPTH≥3 and out_ready held high, one instruction per cycle in steady state.
- FIFO full (count=DEPTH) or count+inflight=DEPTH: im_rd_en=0 until a pop has reduced count in a prior cycle.
- Reset asserted mid-operation: all state is cleared immediately. A response arriving after reset release is ignored because inflight=0.
- out_instr, out_pc and out_pc_next are stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then out_ready=1, memory word = address XOR 0xA5A5:
  - First out_valid in cycle 2 with out_pc=0x0000 and out_pc_next=0x0001.
  - One instruction per cycle thereafter, PCs 0,1,2,...
- out_ready=0 for 10 cycles, DEPTH=4:
  - Exactly 4 reads issued, q_count=4, im_rd_en=0.
  - Head stays 0x0000.
  - Releasing ready drains 0,1,2,3 then continues at 4 without gaps after refill.
- redirect=1 with redirect_pc=0x0040 while q_count=3 and inflight=1:
  - Same cycle: out_valid=0, im_addr=0x0040.
  - Next cycle: q_count=0.
  - 2 cycles later: out_pc=0x0040. Old PCs never appear.
- hlt=1 for 5 cycles mid-stream:
  - No im_rd_en during those cycles; FIFO drains to empty.
  - On release, fetch resumes at the next sequential PC with no duplicate or skipped PC.
  - hlt && redirect to 0x0100 together: resume at 0x0100.
- RESET_PC=0xFFFE, ADDR_W=16:
  - Output PCs 0xFFFE, 0xFFFF, 0x0000.
  - out_pc_next of 0xFFFF is 0x0000.
- rst_n pulsed low while q_count=2 and inflight=1:
  - Outputs are immediately cleared (out_valid=0, q_count=0).
  - After release, first out_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: sequential PC generation, single-cycle memory reads,
// and a DEPTH-entry {instr, pc} prefetch FIFO drained by decode over valid/ready.
module fetch_queue_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hlt,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       im_rd_en,
    output logic [ADDR_W-1:0]          im_addr,
    input  logic [INSTR_W-1:0]         im_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc_next,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    logic               push, pop, issue;
    logic [CW:0]        credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A redirect empties the queue and squashes the in-flight read, so credit
    // is evaluated as if the queue were already empty.
    assign credit_used = redirect ? '0
                                  : ({1'b0, count_q} + (CW+1)'(inflight_q));
    assign issue       = !hlt && (credit_used < (CW+1)'(DEPTH));
    assign im_rd_en    = issue;
    assign im_addr     = redirect ? redirect_pc : fetch_pc_q;

    assign push      = inflight_q && !redirect;
    assign out_valid = (count_q != '0) && !redirect;
    assign pop       = out_valid && out_ready;

    assign out_instr   = (count_q != '0) ? instr_mem[rd_ptr_q] : '0;
    assign out_pc      = (count_q != '0) ? pc_mem[rd_ptr_q]    : '0;
    assign out_pc_next = out_pc + ADDR_W'(1);
    assign q_count     = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (issue) begin
            fetch_pc_d    = im_addr + ADDR_W'(1);
            inflight_pc_d = im_addr;
        end else if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q covers them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    instr_mem[gi] <= im_instr;
                    pc_mem[gi]    <= inflight_pc_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: the expected decode stream is program order from
// the reset PC, restarted at each redirect target; a monitor checks every handshake.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hlt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        im_rd_en;
    logic [15:0] im_addr;
    logic [15:0] im_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_instr, out_pc, out_pc_next;
    logic [2:0]  q_count;

    logic        im_rd_en2;
    logic [15:0] im_addr2;
    logic [15:0] im_instr2 = '0;
    logic        out_valid2;
    logic [15:0] out_instr2, out_pc2, out_pc_next2;
    logic [2:0]  q_count2;

    int checks = 0;
    int passes = 0;
    logic [15:0] exp_q [$];
    logic [15:0] gen_pc = 16'h0000;

    always #5 clk = ~clk;

    fetch_queue_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .hlt(hlt), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_rd_en(im_rd_en), .im_addr(im_addr), .im_instr(im_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .q_count(q_count)
    );

    fetch_queue_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .hlt(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
        .im_rd_en(im_rd_en2), .im_addr(im_addr2), .im_instr(im_instr2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
        .out_pc(out_pc2), .out_pc_next(out_pc_next2), .q_count(q_count2)
    );

    // Synchronous single-cycle instruction memories: word = address ^ 0xA5A5.
    always @(posedge clk) begin
        if (im_rd_en)  im_instr  <= im_addr  ^ 16'hA5A5;
        if (im_rd_en2) im_instr2 <= im_addr2 ^ 16'hA5A5;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    endtask

    task automatic refill();
        while (exp_q.size() < 40) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 16'd1;
        end
    endtask

    task automatic restart(input logic [15:0] pc);
        exp_q.delete();
        gen_pc = pc;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    // Monitor: every accepted head must be the next PC in program order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hlt) check("hlt_no_read", {15'd0, im_rd_en}, 16'd0);
            if (redirect) check("redirect_valid_low", {15'd0, out_valid}, 16'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_empty: got pc 0x%04h, expected nothing", out_pc);
                end else begin
                    logic [15:0] pc;
                    pc = exp_q.pop_front();
                    check("out_pc", out_pc, pc);
                    check("out_instr", out_instr, pc ^ 16'hA5A5);
                    check("out_pc_next", out_pc_next, pc + 16'd1);
                    $display("pop pc=0x%04h instr=0x%04h q=%0d", out_pc, out_instr, q_count);
                end
            end
        end
    end

    initial begin
        int reads;
        int guard;
        restart(16'h0000);
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("rst_valid", {15'd0, out_valid}, 16'd0);
        check("rst_count", {13'd0, q_count}, 16'd0);
        check("rst_instr", out_instr, 16'd0);
        check("rst_pc", out_pc, 16'd0);
        check("rst_pc_next", out_pc_next, 16'd1);

        // Startup latency and streaming
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("c0_rd_en", {15'd0, im_rd_en}, 16'd1);
        check("c0_addr", im_addr, 16'h0000);
        check("c0_valid", {15'd0, out_valid}, 16'd0);
        tick(); @(negedge clk);
        check("c1_valid", {15'd0, out_valid}, 16'd0);
        tick(); @(negedge clk);
        check("c2_valid", {15'd0, out_valid}, 16'd1);
        check("c2_pc", out_pc, 16'h0000);
        check("wrap_pc0", out_pc2, 16'hFFFE);
        check("wrap_next0", out_pc_next2, 16'hFFFF);
        tick(); @(negedge clk);
        check("wrap_pc1", out_pc2, 16'hFFFF);
        check("wrap_next1", out_pc_next2, 16'h0000);
        tick(); @(negedge clk);
        check("wrap_pc2", out_pc2, 16'h0000);
        check("wrap_next2", out_pc_next2, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            tick(); @(negedge clk);
            check("stream_valid", {15'd0, out_valid}, 16'd1);
        end

        // Async reset while two entries are queued and a read is in flight
        tick(); out_ready = 1'b0;
        tick(); @(negedge clk);
        check("pre_rst_count", {13'd0, q_count}, 16'd2);
        #2 rst_n = 1'b0;
        restart(16'h0000);
        #1;
        check("async_rst_valid", {15'd0, out_valid}, 16'd0);
        check("async_rst_count", {13'd0, q_count}, 16'd0);

        // Back-pressure from reset: exactly DEPTH reads, head held at RESET_PC
        tick(); rst_n = 1'b1;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (im_rd_en) reads++;
            tick();
        end
        @(negedge clk);
        check("stall_reads", 16'(reads), 16'd4);
        check("stall_count", {13'd0, q_count}, 16'd4);
        check("stall_rd_en", {15'd0, im_rd_en}, 16'd0);
        check("stall_head", out_pc, 16'h0000);
        tick(); out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("drain_no_gap", {15'd0, out_valid}, 16'd1);
            tick();
        end

        // Redirect with q_count=3 and a read in flight
        out_ready = 1'b0;
        guard = 0;
        tick();
        while (q_count != 3'd3 && guard < 10) begin
            tick();
            guard++;
        end
        check("reach_q3", {13'd0, q_count}, 16'd3);
        redirect = 1'b1; redirect_pc = 16'h0040; out_ready = 1'b1;
        restart(16'h0040);
        @(negedge clk);
        check("redir_addr", im_addr, 16'h0040);
        check("redir_rd_en", {15'd0, im_rd_en}, 16'd1);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("redir_flushed", {13'd0, q_count}, 16'd0);
        tick(); @(negedge clk);
        check("redir_t2_valid", {15'd0, out_valid}, 16'd1);
        check("redir_t2_pc", out_pc, 16'h0040);
        for (int i = 0; i < 4; i++) tick();

        // Halt mid-stream drains the queue; release resumes in order
        hlt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick();
        end
        check("hlt_drained", {13'd0, q_count}, 16'd0);
        hlt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        hlt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        restart(16'h0100);
        tick(); hlt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("hlt_redir_addr", im_addr, 16'h0100);
        for (int i = 0; i < 6; i++) tick();

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            hlt       = ($urandom_range(0, 9) == 0);
            redirect  = ($urandom_range(0, 99) < 3);
            if (redirect) begin
                redirect_pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                          : 16'($urandom);
                restart(redirect_pc);
            end
            tick();
        end
        redirect = 1'b0; hlt = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
